// File: rtl/reg_file_pkg.sv
// Shared CPU-wide constants and types for the architectural register file.
package reg_file_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned CW   = 16;

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam addr_t REG_ZERO = 5'd0;
    localparam addr_t REG_SP   = 5'd29;
    localparam addr_t REG_RA   = 5'd31;

    // Write request as seen by the storage update logic
    typedef struct packed {
        logic  we;
        addr_t wa;
        word_t wd;
    } wr_req_t;

endpackage

// File: rtl/reg_file_if.sv
// Read/write/debug bus between the datapath and the register file.
interface reg_file_if;
    import reg_file_pkg::*;

    addr_t rs_addr;
    addr_t rt_addr;
    addr_t wa;
    word_t wd;
    logic  we;
    addr_t dbg_addr;
    word_t rs_data;
    word_t rt_data;
    word_t dbg_data;
    cnt_t  wr_count;

    modport master (
        output rs_addr, rt_addr, wa, wd, we, dbg_addr,
        input  rs_data, rt_data, dbg_data, wr_count
    );

    modport slave (
        input  rs_addr, rt_addr, wa, wd, we, dbg_addr,
        output rs_data, rt_data, dbg_data, wr_count
    );
endinterface

// File: rtl/reg_file_wdec.sv
// 5-to-32 write-enable decoder; r0 never receives an enable.
module reg_wdec
    import reg_file_pkg::*;
(
    input  addr_t           wa_i,
    input  logic            we_i,
    output logic [NREG-1:0] en_o
);

    // One-hot decode of the write address, bit 0 forced low
    always_comb begin
        en_o = '0;
        if (we_i) begin
            en_o[wa_i] = 1'b1;
        end
        en_o[0] = 1'b0;
    end

endmodule

// File: rtl/reg_file.sv
// 32x32 architectural register file: r0 hardwired to zero, three async
// read ports, one synchronous write port and a committed-write counter.
module reg_file
    import reg_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);

    word_t           regs_q [NREG-1:1];
    word_t           regs_d [NREG-1:1];
    cnt_t            wr_count_q;
    cnt_t            wr_count_d;
    logic [NREG-1:0] wen;
    logic            commit;
    wr_req_t         req;

    assign req = '{we: bus.we, wa: bus.wa, wd: bus.wd};

    reg_wdec u_wdec (
        .wa_i (req.wa),
        .we_i (req.we),
        .en_o (wen)
    );

    assign commit = |wen[NREG-1:1];

    // Next-state for storage and counter from the decoded enables
    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        for (int i = 1; i < NREG; i++) begin
            if (wen[i]) begin
                regs_d[i] = req.wd;
            end
        end
        if (commit) begin
            wr_count_d = wr_count_q + CW'(1);
        end
    end

    // Storage and counter; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Combinational read ports with address 0 returning zero
    always_comb begin
        bus.rs_data  = (bus.rs_addr  == REG_ZERO) ? '0 : regs_q[bus.rs_addr];
        bus.rt_data  = (bus.rt_addr  == REG_ZERO) ? '0 : regs_q[bus.rt_addr];
        bus.dbg_data = (bus.dbg_addr == REG_ZERO) ? '0 : regs_q[bus.dbg_addr];
    end

    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic rst;
    reg_file_if bus ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  we;
        addr_t wa;
        word_t wd;
        addr_t rs;
        addr_t rt;
        addr_t dbg;
        word_t e_rs;
        word_t e_rt;
        word_t e_dbg;
        cnt_t  e_cnt;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vec [NVEC];

    int   n_checks;
    int   n_pass;
    cnt_t exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk_ports(input string name, input word_t e_rs, input word_t e_rt,
                             input word_t e_dbg, input cnt_t e_cnt);
        chk({name, ".rs"},  bus.rs_data,  e_rs);
        chk({name, ".rt"},  bus.rt_data,  e_rt);
        chk({name, ".dbg"}, bus.dbg_data, e_dbg);
        chk({name, ".cnt"}, 32'(bus.wr_count), 32'(e_cnt));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_cnt  = '0;

        vec[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vec[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        16'd1};
        vec[2]  = '{1'b1, 5'd3,  32'h00000011, 5'd3,  5'd8,  5'd0,  32'h11,       32'hDEADBEEF, 32'h0,        16'd2};
        vec[3]  = '{1'b0, 5'd12, 32'hAAAA5555, 5'd12, 5'd3,  5'd8,  32'h0,        32'h11,       32'hDEADBEEF, 16'd2};
        vec[4]  = '{1'b0, 5'd12, 32'hAAAA5555, 5'd12, 5'd3,  5'd8,  32'h0,        32'h11,       32'hDEADBEEF, 16'd2};
        vec[5]  = '{1'b0, 5'd12, 32'hAAAA5555, 5'd12, 5'd3,  5'd8,  32'h0,        32'h11,       32'hDEADBEEF, 16'd2};
        vec[6]  = '{1'b0, 5'd12, 32'hAAAA5555, 5'd12, 5'd3,  5'd8,  32'h0,        32'h11,       32'hDEADBEEF, 16'd2};
        vec[7]  = '{1'b1, 5'd12, 32'h0BADF00D, 5'd12, 5'd12, 5'd12, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 16'd3};
        vec[8]  = '{1'b0, 5'd12, 32'hAAAA5555, 5'd12, 5'd12, 5'd12, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 16'd3};
        vec[9]  = '{1'b0, 5'd12, 32'hAAAA5555, 5'd12, 5'd12, 5'd12, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 16'd3};
        vec[10] = '{1'b1, 5'd31, 32'hCAFEBABE, 5'd31, 5'd29, 5'd31, 32'hCAFEBABE, 32'h0,        32'hCAFEBABE, 16'd4};
        vec[11] = '{1'b1, 5'd29, 32'h00001000, 5'd29, 5'd31, 5'd3,  32'h00001000, 32'hCAFEBABE, 32'h11,       16'd5};

        bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.rs_addr = 5'd8; bus.rt_addr = 5'd31; bus.dbg_addr = 5'd1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_ports("reset", 32'h0, 32'h0, 32'h0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single-edge vectors
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.we = vec[i].we; bus.wa = vec[i].wa; bus.wd = vec[i].wd;
            bus.rs_addr = vec[i].rs; bus.rt_addr = vec[i].rt; bus.dbg_addr = vec[i].dbg;
            @(posedge clk);
            #1;
            chk_ports($sformatf("vec%0d", i), vec[i].e_rs, vec[i].e_rt, vec[i].e_dbg, vec[i].e_cnt);
        end
        exp_cnt = 16'd5;

        // Read during write: old value before the edge, new after
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h22;
        bus.rs_addr = 5'd3; bus.rt_addr = 5'd3; bus.dbg_addr = 5'd3;
        #1;
        chk_ports("rdw_pre", 32'h11, 32'h11, 32'h11, exp_cnt);
        @(posedge clk);
        #1;
        exp_cnt++;
        chk_ports("rdw_post", 32'h22, 32'h22, 32'h22, exp_cnt);

        // Sweep r1..r31
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            bus.we = 1'b1; bus.wa = 5'(i); bus.wd = 32'(i) * 32'h01010101;
            exp_cnt++;
        end
        @(negedge clk);
        bus.we = 1'b0;
        for (int i = 1; i < 32; i++) begin
            bus.rs_addr = 5'(i); bus.rt_addr = 5'(i); bus.dbg_addr = 5'(i);
            #1;
            chk_ports($sformatf("sweep%0d", i), 32'(i) * 32'h01010101,
                      32'(i) * 32'h01010101, 32'(i) * 32'h01010101, exp_cnt);
        end

        // 65536 committed writes wrap the counter back to its start value
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            bus.we = 1'b1;
            bus.wa = 5'((i % 31) + 1);
            bus.wd = 32'((i % 31) + 1) * 32'h01010101;
            if (i == 65535) begin
                chk("wrap_minus1", 32'(bus.wr_count), 32'(exp_cnt - 16'd1));
            end
        end
        @(negedge clk);
        bus.we = 1'b0;
        bus.rs_addr = REG_SP; bus.rt_addr = REG_RA; bus.dbg_addr = 5'd0;
        #1;
        chk_ports("wrap", 32'd29 * 32'h01010101, 32'd31 * 32'h01010101, 32'h0, exp_cnt);

        // Asynchronous reset mid-cycle after loading r5
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h12345678;
        bus.rs_addr = 5'd5; bus.rt_addr = 5'd5; bus.dbg_addr = 5'd5;
        @(posedge clk);
        #1;
        exp_cnt++;
        chk_ports("r5_load", 32'h12345678, 32'h12345678, 32'h12345678, exp_cnt);
        @(negedge clk);
        bus.we = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_ports("rst_async", 32'h0, 32'h0, 32'h0, 16'd0);

        // Writes ignored while reset held
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h77;
        bus.rs_addr = 5'd7; bus.rt_addr = 5'd7; bus.dbg_addr = 5'd7;
        @(posedge clk);
        #1;
        chk_ports("rst_hold", 32'h0, 32'h0, 32'h0, 16'd0);

        // First edge after release commits
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_ports("post_rst", 32'h77, 32'h77, 32'h77, 16'd1);
        bus.we = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file of the single-cycle CPU: 32 registers × 32 bits, two asynchronous read ports (rs, rt), one synchronous write port and a debug read port for the board display. It sits directly downstream of the 5-bit write-destination select (rt/rd). That select's output drives `wa`; the ALU or memory result mux drives `wd`. Register 0 is hardwired to zero. A committed-write counter supports bring-up and debug.

## Interface
Parameters:
- `DW`, 32, data width of every register.
- `AW`, 5, register address width; depth is 2^AW = 32.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset. One clock domain.
- `rs_addr` input AW: read port A address.
- `rt_addr` input AW: read port B address.
- `wa` input AW: write address, from the 5-bit destination select.
- `wd` input DW: write data.
- `we` input 1: write enable (RegWrite).
- `rs_data` output DW: contents of `rs_addr`.
- `rt_data` output DW: contents of `rt_addr`.
- `dbg_addr` input AW: debug read address.
- `dbg_data` output DW: contents of `dbg_addr`.
- `wr_count` output 16: number of committed writes, wraps.

## Operation
- Storage: 31 physical registers, r1..r31. r0 is not stored. Any read of address 0 returns 0.
- Write:
  - On a rising `clk` edge with `we`=1 and `wa`≠0, the register at `wa` takes `wd`.
  - `wa`=0 with `we`=1 is silently discarded: no register changes and `wr_count` does not increment.
  - `we`=0: no change.
- Reads:
  - All three read ports are purely combinational from storage.
  - A read of the register being written in the same cycle returns the old value until the edge, then the new value. There is no internal bypass; the single-cycle datapath does not need one.
- `wr_count`: increments by 1 on each committed write (`we`=1 and `wa`≠0). Wraps 0xFFFF→0x0000 with no flag.
- Reset, asserted at any time including mid-cycle:
  - All registers, `rs_data`, `rt_data`, `dbg_data` and `wr_count` go to 0 immediately, without waiting for `clk`.
  - While `rst`=1, writes are ignored.
  - The first write can commit on the first rising edge after `rst` deasserts.
- Unknown or X addresses are not checked; behaviour is undefined.

## Timing
- Read latency is 0 cycles, combinational from address to data.
- Write latency is 1 edge: data is visible on the read ports immediately after the edge it commits on.
- `wr_count` updates on the same edge as the write it counts.
- Simultaneous events in one cycle:
  - `rs_addr`=`rt_addr`=`wa`=k≠0 with `we`=1: both read ports show the old r[k] before the edge and `wd` after it.
  - Same-address reads on all three ports are legal and all return identical data.
- Reset has priority over a write on the same edge.

## Structure
- Shared constants go in the CPU-wide definitions package/include: `REG_ZERO` = 5'd0, `DW`, `AW`, and the debug register index names (e.g. `REG_SP` = 29, `REG_RA` = 31).
- One sub-module is natural: `reg_wdec`, a 5-to-32 write-enable decoder.
  - Inputs: `wa`, `we`. Output: a 32-bit one-hot enable with bit 0 forced 0.
  - Its output gates the per-register loads and feeds the `wr_count` increment (OR of bits 31..1).
- Read muxes are inline in `reg_file`.

## Test plan
- **Reset:** assert `rst` mid-cycle after loading r5=0x12345678 -> `rs_data` (`rs_addr`=5) reads 0 before the next edge; `wr_count`=0.
- **Basic write/read:**
  - Stimulus: `we`=1, `wa`=8, `wd`=0xDEADBEEF, one edge.
  - Response: `rs_addr`=8 and `rt_addr`=8 both read 0xDEADBEEF; `dbg_addr`=8 matches; `wr_count`=1.
- **r0 hardwired:** `we`=1, `wa`=0, `wd`=0xFFFFFFFF -> all ports at address 0 read 0; `wr_count` unchanged.
- **Read-during-write:**
  - Setup: r3=0x11.
  - Stimulus: `we`=1, `wa`=3, `wd`=0x22, `rs_addr`=3.
  - Response: `rs_data`=0x11 before the edge, 0x22 after.
- **we low:** `we`=0, `wa`=12, `wd`=0xAAAA5555 for 4 edges -> r12 keeps its prior value; `wr_count` unchanged.
- **Sweep and wrap:**
  - Write r1..r31 with value = index×0x01010101 and read each back on all three ports.
  - Then perform 65536 committed writes -> `wr_count` returns to the same value it had before those writes.
